// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: block-fetch instruction prefetch queue feeding ID one instruction per cycle
module if_prefetch_queue #(
  parameter logic [31:0] RESET_PC    = 32'hBFC00000,
  parameter int          FETCH_WIDTH = 2,
  parameter int          DEPTH       = 4
) (
  input  logic                           CLK,
  input  logic                           RESET,
  output logic [31:0]                    Instr_address_2IM,
  input  logic [32*FETCH_WIDTH-1:0]      Instr_fIM,
  input  logic                           STALL,
  input  logic                           Request_Alt_PC,
  input  logic [31:0]                    Alt_PC,
  output logic [31:0]                    Instr1_OUT,
  output logic [31:0]                    Instr_PC_OUT,
  output logic [31:0]                    Instr_PC_Plus4,
  output logic                           Instr_Valid,
  output logic [$clog2(DEPTH+1)-1:0]     Queue_Count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   fetch_pc_q, fetch_pc_d, block_pc;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, off, n_words;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q [DEPTH];
  logic          fire, pop, valid;
  assign block_pc    = fetch_pc_q & ~32'(4 * FETCH_WIDTH - 1);
  assign off         = CW'((fetch_pc_q >> 2) & 32'(FETCH_WIDTH - 1));
  assign n_words     = CW'(FETCH_WIDTH) - off;
  assign valid       = count_q != '0;
  assign fire        = !Request_Alt_PC && (CW'(DEPTH) - count_q >= n_words);
  assign pop         = valid && !STALL && !Request_Alt_PC;
  assign Instr_address_2IM = block_pc;
  assign Instr_Valid       = valid;
  assign Queue_Count       = count_q;
  assign Instr1_OUT        = valid ? instr_q[head_q] : 32'd0;
  assign Instr_PC_OUT      = valid ? pc_q[head_q] : 32'd0;
  assign Instr_PC_Plus4    = valid ? pc_q[head_q] + 32'd4 : 32'd0;
  // Next-state for pointers, occupancy and fetch PC; a redirect overrides everything
  always_comb begin
    head_d     = Request_Alt_PC ? '0 : head_q + AW'(pop);
    tail_d     = Request_Alt_PC ? '0 : fire ? tail_q + AW'(n_words) : tail_q;
    count_d    = Request_Alt_PC ? '0 : count_q + (fire ? n_words : '0) - CW'(pop);
    fetch_pc_d = Request_Alt_PC ? {Alt_PC[31:2], 2'b00} :
                 fire ? block_pc + 32'(4 * FETCH_WIDTH) : fetch_pc_q;
  end
  // Control registers; reset empties the queue immediately
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end
  // Queue storage: words from the block offset onward land in address order at the tail
  always_ff @(posedge CLK) begin
    for (int k = 0; k < FETCH_WIDTH; k++)
      if (fire && CW'(k) >= off) begin
        instr_q[tail_q + AW'(k) - AW'(off)] <= Instr_fIM[32*k +: 32];
        pc_q[tail_q + AW'(k) - AW'(off)]    <= block_pc + 32'(4 * k);
      end
  end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed self-checking bench for the prefetch queue (FW=2, DEPTH=4)
module tb_if_prefetch_queue;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] Instr_address_2IM;
  logic [63:0] Instr_fIM;
  logic        STALL = 1'b0;
  logic        Request_Alt_PC = 1'b0;
  logic [31:0] Alt_PC = 32'd0;
  logic [31:0] Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4;
  logic        Instr_Valid;
  logic [2:0]  Queue_Count;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_pc;

  if_prefetch_queue #(.RESET_PC(32'hBFC00000), .FETCH_WIDTH(2), .DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .Instr_address_2IM(Instr_address_2IM), .Instr_fIM(Instr_fIM),
    .STALL(STALL), .Request_Alt_PC(Request_Alt_PC), .Alt_PC(Alt_PC),
    .Instr1_OUT(Instr1_OUT), .Instr_PC_OUT(Instr_PC_OUT), .Instr_PC_Plus4(Instr_PC_Plus4),
    .Instr_Valid(Instr_Valid), .Queue_Count(Queue_Count)
  );

  always #5 CLK = ~CLK;
  assign Instr_fIM = {Instr_address_2IM + 32'd4, Instr_address_2IM};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(Instr_Valid), 32'd1);
    chk({tag, "_pc"}, Instr_PC_OUT, pc);
    chk({tag, "_instr"}, Instr1_OUT, pc);
    chk({tag, "_plus4"}, Instr_PC_Plus4, pc + 32'd4);
  endtask

  task automatic expect_empty(input string tag);
    chk({tag, "_valid"}, 32'(Instr_Valid), 32'd0);
    chk({tag, "_pc"}, Instr_PC_OUT, 32'd0);
    chk({tag, "_instr"}, Instr1_OUT, 32'd0);
    chk({tag, "_plus4"}, Instr_PC_Plus4, 32'd0);
    chk({tag, "_count"}, 32'(Queue_Count), 32'd0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    Request_Alt_PC = 1'b1;
    Alt_PC = target;
    @(negedge CLK);
    Request_Alt_PC = 1'b0;
  endtask

  initial begin
    do_reset();
    expect_empty("rst");
    chk("rst_addr", Instr_address_2IM, 32'hBFC00000);
    @(negedge CLK);
    expect_head("first", 32'hBFC00000);
    chk("first_count", 32'(Queue_Count), 32'd2);
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      expect_head("seq", 32'hBFC00000 + 32'(4 * i));
    end

    STALL = 1'b1;
    do_reset();
    chk("stall_c0", 32'(Queue_Count), 32'd0);
    @(negedge CLK);
    chk("stall_c1", 32'(Queue_Count), 32'd2);
    expect_head("stall_h1", 32'hBFC00000);
    @(negedge CLK);
    chk("stall_c2", 32'(Queue_Count), 32'd4);
    chk("stall_addr2", Instr_address_2IM, 32'hBFC00010);
    @(negedge CLK);
    chk("stall_c3", 32'(Queue_Count), 32'd4);
    chk("stall_addr3", Instr_address_2IM, 32'hBFC00010);
    expect_head("stall_h3", 32'hBFC00000);
    STALL = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge CLK);
      expect_head("drain", 32'hBFC00000 + 32'(4 * i));
    end

    redirect(32'h80000106);
    expect_empty("redir");
    chk("redir_addr", Instr_address_2IM, 32'h80000100);
    @(negedge CLK);
    expect_head("redir_h1", 32'h80000104);
    chk("redir_c1", 32'(Queue_Count), 32'd1);
    chk("redir_addr1", Instr_address_2IM, 32'h80000108);
    @(negedge CLK);
    expect_head("redir_h2", 32'h80000108);
    chk("redir_c2", 32'(Queue_Count), 32'd2);

    STALL = 1'b1;
    @(negedge CLK);
    chk("full_count", 32'(Queue_Count), 32'd4);
    expect_head("full_head", 32'h80000108);
    redirect(32'h00001000);
    expect_empty("fullredir");
    chk("fullredir_addr", Instr_address_2IM, 32'h00001000);
    @(negedge CLK);
    expect_head("fullredir_h", 32'h00001000);
    chk("fullredir_c", 32'(Queue_Count), 32'd2);

    STALL = 1'b0;
    redirect(32'hFFFFFFF8);
    chk("wrap_addr0", Instr_address_2IM, 32'hFFFFFFF8);
    @(negedge CLK);
    expect_head("wrap_h0", 32'hFFFFFFF8);
    chk("wrap_addr1", Instr_address_2IM, 32'h00000000);
    @(negedge CLK);
    expect_head("wrap_h1", 32'hFFFFFFFC);
    chk("wrap_plus4", Instr_PC_Plus4, 32'h00000000);
    @(negedge CLK);
    expect_head("wrap_h2", 32'h00000000);

    redirect(32'h00002000);
    exp_pc = 32'h00002000;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      chk("rand_cnt_le4", 32'(Queue_Count <= 3'd4), 32'd1);
      if (Instr_Valid) chk("rand_pc", Instr_PC_OUT, exp_pc);
      STALL = 1'($urandom_range(0, 1));
      if (Instr_Valid && !STALL) exp_pc = exp_pc + 32'd4;
    end
    STALL = 1'b0;

    do_reset();
    repeat (2) @(negedge CLK);
    chk("mid_count3", 32'(Queue_Count), 32'd3);
    #2 RESET = 1'b1;
    #1;
    expect_empty("async_rst");
    chk("async_addr", Instr_address_2IM, 32'hBFC00000);
    @(negedge CLK);
    RESET = 1'b0;
    expect_empty("post_rst");
    @(negedge CLK);
    expect_head("post_rst_h", 32'hBFC00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
